// File: rtl/id_ex_stage.sv
// ID/EX stage of the in-order RV32 core: immediate generation, load-use hazard detection, ID/EX register.
// Optional perf counters (stall_cnt, flush_cnt) are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    output logic [6:0]      opcode,
    output logic [4:0]      funct5,
    input  logic            reg_write,
    input  logic            imm_data,
    input  logic            mem_to_reg,
    input  logic            branch,
    input  logic            wb_pc,
    input  logic            cond_b,
    input  logic            store,
    input  logic            jalr,
    input  logic            auipc,
    input  logic            lui,
    input  logic            is_fstore,
    input  logic [1:0]      opcode_alu,
    input  logic            ex_ready,
    input  logic            ex_flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic            ex_ctrl_reg_write,
    output logic            ex_ctrl_imm_data,
    output logic            ex_ctrl_mem_to_reg,
    output logic            ex_ctrl_branch,
    output logic            ex_ctrl_wb_pc,
    output logic            ex_ctrl_cond_b,
    output logic            ex_ctrl_store,
    output logic            ex_ctrl_jalr,
    output logic            ex_ctrl_auipc,
    output logic            ex_ctrl_lui,
    output logic            ex_ctrl_is_fstore,
    output logic [1:0]      ex_ctrl_opcode_alu
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    localparam logic [4:0] OP_LOAD  = 5'b00000, OP_FLOAD = 5'b00001, OP_IMM  = 5'b00100,
                           OP_AUIPC = 5'b00101, OP_STORE = 5'b01000, OP_FSTORE = 5'b01001,
                           OP_OP    = 5'b01100, OP_LUI   = 5'b01101, OP_BRANCH = 5'b11000,
                           OP_JALR  = 5'b11001, OP_JAL   = 5'b11011;

    typedef struct packed {
        logic [1:0] opcode_alu;
        logic       reg_write, imm_data, mem_to_reg, branch, wb_pc, cond_b;
        logic       store, jalr, auipc, lui, is_fstore;
    } ctrl_t;

    ctrl_t       ctrl_in, ctrl_q;
    logic [4:0]  op5, rs1, rs2;
    logic [31:0] imm32;
    logic        uses_rs1, uses_rs2, haz;

    assign opcode  = if_instr[6:0];
    assign funct5  = if_instr[31:27];
    assign op5     = if_instr[6:2];
    assign rs1     = if_instr[19:15];
    assign rs2     = if_instr[24:20];
    assign ctrl_in = {opcode_alu, reg_write, imm_data, mem_to_reg, branch, wb_pc, cond_b,
                      store, jalr, auipc, lui, is_fstore};

    always_comb begin
        imm32 = '0;
        case (op5)
            OP_IMM, OP_LOAD, OP_FLOAD, OP_JALR:
                imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            OP_STORE, OP_FSTORE:
                imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OP_BRANCH:
                imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {if_instr[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign uses_rs1 = !(op5 inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign uses_rs2 = op5 inside {OP_OP, OP_BRANCH, OP_STORE, OP_FSTORE};
    assign haz      = ex_valid && ctrl_q.mem_to_reg && (ex_rd != 5'd0) &&
                      ((ex_rd == rs1 && uses_rs1) || (ex_rd == rs2 && uses_rs2));
    assign id_ready = (ex_ready && !haz) || ex_flush;

    // A slot that is not a live instruction always carries cleared control so EX can't act on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_imm    <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_funct3 <= '0;
            ex_funct7 <= '0;
            ctrl_q    <= '0;
        end else if (ex_flush) begin
            ex_valid <= 1'b0;
            ctrl_q   <= '0;
        end else if (ex_ready) begin
            if (haz || !if_valid) begin
                ex_valid <= 1'b0;
                ctrl_q   <= '0;
            end else begin
                ex_valid  <= 1'b1;
                ex_pc     <= if_pc;
                ex_imm    <= XLEN'($signed(imm32));
                ex_rs1    <= rs1;
                ex_rs2    <= rs2;
                ex_rd     <= if_instr[11:7];
                ex_funct3 <= if_instr[14:12];
                ex_funct7 <= if_instr[31:25];
                ctrl_q    <= ctrl_in;
            end
        end
    end

    assign ex_ctrl_reg_write  = ctrl_q.reg_write;
    assign ex_ctrl_imm_data   = ctrl_q.imm_data;
    assign ex_ctrl_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_ctrl_branch     = ctrl_q.branch;
    assign ex_ctrl_wb_pc      = ctrl_q.wb_pc;
    assign ex_ctrl_cond_b     = ctrl_q.cond_b;
    assign ex_ctrl_store      = ctrl_q.store;
    assign ex_ctrl_jalr       = ctrl_q.jalr;
    assign ex_ctrl_auipc      = ctrl_q.auipc;
    assign ex_ctrl_lui        = ctrl_q.lui;
    assign ex_ctrl_is_fstore  = ctrl_q.is_fstore;
    assign ex_ctrl_opcode_alu = ctrl_q.opcode_alu;

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (haz && ex_ready && !ex_flush) stall_cnt <= stall_cnt + 32'd1;
            if (ex_flush && (ex_valid || if_valid)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed program snippets, then randomized traffic against a reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, if_valid, ex_ready, ex_flush;
    logic [31:0] if_instr, if_pc;
    logic [12:0] cin;
    logic        id_ready;
    logic [6:0]  opcode;
    logic [4:0]  funct5;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        c_rw, c_imm, c_m2r, c_br, c_wbpc, c_cb, c_st, c_jalr, c_auipc, c_lui, c_fst;
    logic [1:0]  c_alu;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_valid;
    logic [31:0] m_pc, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [12:0] m_ctl;
    logic [31:0] m_stall, m_flush;

    always #5 clk = ~clk;

    // control bundle order: {alu[1:0], rw, imm, m2r, br, wbpc, condb, st, jalr, auipc, lui, fst}
    assign {c_alu, c_rw, c_imm, c_m2r, c_br, c_wbpc, c_cb, c_st, c_jalr, c_auipc, c_lui, c_fst} = cin;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .opcode(opcode), .funct5(funct5),
        .reg_write(c_rw), .imm_data(c_imm), .mem_to_reg(c_m2r), .branch(c_br), .wb_pc(c_wbpc),
        .cond_b(c_cb), .store(c_st), .jalr(c_jalr), .auipc(c_auipc), .lui(c_lui),
        .is_fstore(c_fst), .opcode_alu(c_alu), .ex_ready(ex_ready), .ex_flush(ex_flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_ctrl_reg_write(), .ex_ctrl_imm_data(), .ex_ctrl_mem_to_reg(), .ex_ctrl_branch(),
        .ex_ctrl_wb_pc(), .ex_ctrl_cond_b(), .ex_ctrl_store(), .ex_ctrl_jalr(),
        .ex_ctrl_auipc(), .ex_ctrl_lui(), .ex_ctrl_is_fstore(), .ex_ctrl_opcode_alu()
`ifdef ID_EX_PERF_CNT_EN
        , .stall_cnt(stall_cnt_o), .flush_cnt(flush_cnt_o)
`endif
    );

`ifndef ID_EX_PERF_CNT_EN
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

    wire [12:0] obs_ctl = {dut.ex_ctrl_opcode_alu, dut.ex_ctrl_reg_write, dut.ex_ctrl_imm_data,
                           dut.ex_ctrl_mem_to_reg, dut.ex_ctrl_branch, dut.ex_ctrl_wb_pc,
                           dut.ex_ctrl_cond_b, dut.ex_ctrl_store, dut.ex_ctrl_jalr,
                           dut.ex_ctrl_auipc, dut.ex_ctrl_lui, dut.ex_ctrl_is_fstore};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Immediate value computed arithmetically from the instruction fields.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int s;
        s = ins[31] ? -1 : 0;
        case (ins[6:2])
            5'h00, 5'h01, 5'h04, 5'h19: return 32'(s * 2048 + int'(ins[30:20]));
            5'h08, 5'h09: return 32'(s * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]));
            5'h18: return 32'(s * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
            5'h05, 5'h0D: return 32'(ins[31:12]) * 32'd4096;
            5'h1B: return 32'(s * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_haz(input logic [31:0] ins);
        logic [4:0] op;
        logic u1, u2;
        op = ins[6:2];
        u1 = !(op == 5'h0D || op == 5'h05 || op == 5'h1B);   // lui, auipc, jal
        u2 = (op == 5'h0C || op == 5'h18 || op == 5'h08 || op == 5'h09);
        return m_valid && m_ctl[8] && m_rd != 0 &&
               ((m_rd == ins[19:15] && u1) || (m_rd == ins[24:20] && u2));
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [12:0] c, input logic rdy, input logic fl);
        if_valid = v; if_instr = ins; if_pc = pc; cin = c; ex_ready = rdy; ex_flush = fl;
    endtask

    // One cycle: check combinational outputs, advance model, clock, check registered state.
    task automatic step();
        logic h;
        #1;
        h = ref_haz(if_instr);
        chk("id_ready", 128'(id_ready), 128'((ex_ready && !h) || ex_flush));
        chk("decode", 128'({opcode, funct5}), 128'({if_instr[6:0], if_instr[31:27]}));
        if (rst) begin
            m_valid = 0; m_pc = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
            m_f3 = 0; m_f7 = 0; m_ctl = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (h && ex_ready && !ex_flush) m_stall++;
            if (ex_flush && (m_valid || if_valid)) m_flush++;
            if (ex_flush) begin
                m_valid = 0; m_ctl = 0;
            end else if (ex_ready) begin
                if (h || !if_valid) begin
                    m_valid = 0; m_ctl = 0;
                end else begin
                    m_valid = 1; m_pc = if_pc; m_imm = ref_imm(if_instr);
                    m_rs1 = if_instr[19:15]; m_rs2 = if_instr[24:20]; m_rd = if_instr[11:7];
                    m_f3 = if_instr[14:12]; m_f7 = if_instr[31:25]; m_ctl = cin;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("ex_valid", 128'(ex_valid), 128'(m_valid));
        chk("ex_ctrl", 128'(obs_ctl), 128'(m_ctl));
        chk("ex_fields", 128'({ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7}),
                         128'({m_pc, m_imm, m_rs1, m_rs2, m_rd, m_f3, m_f7}));
`ifdef ID_EX_PERF_CNT_EN
        chk("counters", 128'({stall_cnt_o, flush_cnt_o}), 128'({m_stall, m_flush}));
`endif
    endtask

    localparam logic [12:0] C_ADDI = {2'b01, 11'b11000000000};
    localparam logic [12:0] C_LW   = {2'b00, 11'b11100000000};
    localparam logic [12:0] C_ADD  = {2'b10, 11'b10000000000};
    localparam logic [12:0] C_LUI  = {2'b00, 11'b11000000010};
    localparam logic [12:0] C_BEQ  = {2'b00, 11'b00010100000};
    localparam logic [12:0] C_SW   = {2'b00, 11'b01000010000};
    localparam logic [12:0] C_JAL  = {2'b00, 11'b10011000000};

    initial begin
        logic [6:0] ops [12];
        logic [31:0] r;
        logic [31:0] sw_fields;
        ops = '{7'h03, 7'h07, 7'h13, 7'h17, 7'h23, 7'h27, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h0B};

        rst = 1; drive(0, 32'h0, 32'h0, '0, 1, 0);
        step(); step();
        chk("reset_ready", 128'(id_ready), 128'(1));
        rst = 0;

        // addi x5,x0,-1
        drive(1, 32'hFFF00293, 32'h100, C_ADDI, 1, 0); step();
        chk("addi_imm", 128'(ex_imm), 128'(32'hFFFFFFFF));
        chk("addi_rd", 128'(ex_rd), 128'(5));
        chk("addi_alu", 128'({dut.ex_ctrl_reg_write, dut.ex_ctrl_opcode_alu}), 128'(3'b101));

        // lw x6,0(x1); add x7,x6,x2 -> one bubble
        drive(1, 32'h0000A303, 32'h104, C_LW, 1, 0); step();
        drive(1, 32'h002303B3, 32'h108, C_ADD, 1, 0); step();
        chk("bubble_valid", 128'(ex_valid), 128'(0));
        step();
        chk("add_issued", 128'({ex_valid, ex_rd}), 128'({1'b1, 5'd7}));
`ifdef ID_EX_PERF_CNT_EN
        chk("stall_cnt_1", 128'(stall_cnt_o), 128'(1));
`endif

        // lw x0 then add using x0: no stall; lw x6 then lui x6: no stall
        drive(1, 32'h0000A003, 32'h10C, C_LW, 1, 0); step();
        drive(1, 32'h002003B3, 32'h110, C_ADD, 1, 0); step();
        drive(1, 32'h0000A303, 32'h114, C_LW, 1, 0); step();
        drive(1, 32'h12345337, 32'h118, C_LUI, 1, 0); step();
        chk("lui_no_stall", 128'({ex_valid, ex_imm}), 128'({1'b1, 32'h12345000}));

        // lw x6 then beq x6,x2 with flush: flush wins over hazard
        drive(1, 32'h0000A303, 32'h11C, C_LW, 1, 0); step();
        drive(1, 32'h00230463, 32'h120, C_BEQ, 1, 1); step();
        chk("flush_valid", 128'(ex_valid), 128'(0));
`ifdef ID_EX_PERF_CNT_EN
        chk("flush_cnt_1", 128'({stall_cnt_o, flush_cnt_o}), 128'({32'd1, 32'd1}));
`endif

        // sw x2,8(x1) held for 3 cycles of ex_ready=0
        drive(1, 32'h0020A423, 32'h200, C_SW, 1, 0); step();
        sw_fields = ex_imm;
        chk("sw_imm", 128'(sw_fields), 128'(8));
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h00500593, 32'h204, C_ADDI, 0, 0); step();
            chk("hold_stable", 128'({ex_valid, ex_imm, dut.ex_ctrl_store}), 128'({1'b1, 32'd8, 1'b1}));
        end
        drive(1, 32'h00500593, 32'h204, C_ADDI, 1, 0); step();
        chk("release_load", 128'({ex_pc, ex_rd}), 128'({32'h204, 5'd11}));

        // jal x1,-4
        drive(1, 32'hFFDFF0EF, 32'h208, C_JAL, 1, 0); step();
        chk("jal_imm", 128'({ex_imm, dut.ex_ctrl_branch, dut.ex_ctrl_wb_pc}), 128'({32'hFFFFFFFC, 2'b11}));

        // Reset during a pending hazard
        drive(1, 32'h0000A303, 32'h300, C_LW, 1, 0); step();
        drive(1, 32'h002303B3, 32'h304, C_ADD, 1, 0); rst = 1; step();
        rst = 0; #1;
        chk("rst_mid_stall", 128'({ex_valid, id_ready}), 128'({1'b0, ex_ready}));

        // Randomized traffic with a narrow register range to provoke hazards
        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            r[6:0]   = ops[$urandom_range(0, 11)];
            r[11:7]  = 5'($urandom_range(0, 3));
            r[19:15] = 5'($urandom_range(0, 3));
            r[24:20] = 5'($urandom_range(0, 3));
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 4) != 0, r, $urandom, 13'($urandom),
                  $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
